imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 37 +++
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 210 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and FSM state type for the instruction-memory
//               loader. Optional macro IMEM_LOADER_CSUM_EN adds the CSUM state.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int HDR_BYTES  = 2;

`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5,
        S_CSUM  = 3'd6
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } loader_state_t;
`endif

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream handshake plus instruction-memory write port.
//               master = loader side, slave = byte source / memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_word_packer
// Description : Packs accepted bytes little-endian into a 32-bit word.
//               o_word_ready flags the byte that completes the word.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer
    import imem_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              n_rst,
    input  wire logic              i_clear,
    input  wire logic              i_byte_en,
    input  wire logic [BYTE_W-1:0] i_byte,
    output logic      [WORD_W-1:0] o_word,
    output logic                   o_word_ready
);
    localparam int c_BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int c_CNT_W          = $clog2(c_BYTES_PER_WORD);

    logic [c_CNT_W-1:0] r_cnt;
    logic [WORD_W-1:0]  r_word;

    // Byte lane select; the counter wraps naturally after the last lane.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_byte_en) begin
            r_word[BYTE_W*r_cnt +: BYTE_W] <= i_byte;
            r_cnt                          <= r_cnt + 1'b1;
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_byte_en && (r_cnt == c_CNT_W'(c_BYTES_PER_WORD - 1));

endmodule : imem_word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a length-prefixed byte stream, packs it into words
//               and writes them to instruction memory from address 0 while
//               holding the core. Optional macro IMEM_LOADER_CSUM_EN adds an
//               XOR trailer byte checked after the last word.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic     clk,
    input  wire logic     n_rst,
    input  wire logic     start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);
    loader_state_t      r_state;
    logic [ADDR_W:0]    r_idx;      // one extra bit so N == DEPTH compares cleanly
    logic [15:0]        r_n;
    logic               r_hdr_cnt;
    logic               r_rx_ready;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_hold;

    logic               w_accept;
    logic [15:0]        w_n_full;
    logic               w_pk_en;
    logic               w_pk_clear;
    logic               w_word_ready;
    logic [WORD_W-1:0]  w_word;
    logic               w_idx_last;

    assign w_accept   = bus.rx_valid && r_rx_ready;
    assign w_n_full   = {bus.rx_data, r_n[7:0]};
    assign w_pk_en    = w_accept && (r_state == S_DATA);
    assign w_pk_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERROR));
    assign w_idx_last = (({{(15-ADDR_W){1'b0}}, r_idx} + 16'd1) == r_n);

    imem_word_packer u_packer (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_clear      (w_pk_clear),
        .i_byte_en    (w_pk_en),
        .i_byte       (bus.rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] r_csum;

    // Running XOR over data bytes only; restarted with every new load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_csum <= '0;
        end else if (w_pk_clear) begin
            r_csum <= '0;
        end else if (w_pk_en) begin
            r_csum <= r_csum ^ bus.rx_data;
        end
    end
`endif

    // Load sequencer with registered handshake, write and status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_n        <= '0;
            r_hdr_cnt  <= 1'b0;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_done    <= 1'b0;
                    r_error   <= 1'b0;
                    r_idx     <= '0;
                    r_hdr_cnt <= 1'b0;
                    if (start) begin
                        r_state    <= S_HDR;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_hold     <= 1'b1;
                    end
                end

                S_HDR: begin
                    if (w_accept) begin
                        if (r_hdr_cnt == 1'(HDR_BYTES - 1)) begin
                            r_n       <= w_n_full;
                            r_hdr_cnt <= 1'b0;
                            if (w_n_full == 16'd0) begin
                                r_state    <= S_DONE;
                                r_rx_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_hold     <= 1'b0;
                                r_done     <= 1'b1;
                            end else if (w_n_full > 16'(DEPTH)) begin
                                r_state    <= S_ERROR;
                                r_rx_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_error    <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_n[7:0]  <= bus.rx_data;
                            r_hdr_cnt <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (w_word_ready) begin
                        r_state    <= S_WRITE;
                        r_rx_ready <= 1'b0;
                        r_we       <= 1'b1;
                        r_waddr    <= r_idx[ADDR_W-1:0];
                    end
                end

                S_WRITE: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_idx_last) begin
`ifdef IMEM_LOADER_CSUM_EN
                        r_state    <= S_CSUM;
                        r_rx_ready <= 1'b1;
`else
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_hold     <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else begin
                        r_state    <= S_DATA;
                        r_rx_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.rx_data == r_csum) begin
                            r_state <= S_DONE;
                            r_hold  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_HDR;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_idx      <= '0;
                        r_hdr_cnt  <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_hold     <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_hold     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready = r_rx_ready;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = w_word;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign cpu_hold     = r_hold;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected memory writes
//               are queued as bytes are sent and popped at each we pulse.
//               Honours IMEM_LOADER_CSUM_EN by sending trailer bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    import imem_pkg::*;

    localparam int DEPTH = 32;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic n_rst;
    logic start;
    logic busy, done, error, cpu_hold;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_we  = 0;
    wr_t  sb[$];
    logic [7:0] tb_csum;

    imem_loader_if #(.DEPTH(DEPTH)) bus ();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the oldest queued expectation
    // and must happen with rx_ready deasserted.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && bus.we === 1'b1) begin
            wr_t e;
            n_we++;
            n_cmp++;
            if (bus.rx_ready !== 1'b0) begin
                n_err++;
                $display("FAIL write_rx_ready: got %b want 0", bus.rx_ready);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected",
                         bus.waddr, bus.wdata);
            end else begin
                e = sb.pop_front();
                if ({bus.waddr, bus.wdata} !== {e.a, e.d}) begin
                    n_err++;
                    $display("FAIL write: got addr %0d data %h want addr %0d data %h",
                             bus.waddr, bus.wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_ready_timeout: byte %h never accepted", b);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [4:0] a, input logic [31:0] w, input int max_gap);
        wr_t e;
        e.a = a;
        e.d = w;
        sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(w[8*k +: 8]);
            tb_csum = tb_csum ^ w[8*k +: 8];
        end
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic pulse_start();
        start   = 1'b1;
        tb_csum = 8'h00;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic end_load();
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(tb_csum);
`endif
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: done=%b error=%b", done, error);
        end
    endtask

    task automatic test_reset();
        n_rst        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, error, cpu_hold, bus.rx_ready, bus.we, bus.waddr, bus.wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_in: busy%b done%b err%b hold%b rdy%b we%b waddr%0d wdata%h, want all 0",
                     busy, done, error, cpu_hold, bus.rx_ready, bus.we, bus.waddr, bus.wdata);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, error, cpu_hold, bus.rx_ready, bus.we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy%b done%b err%b hold%b rdy%b we%b, want all 0",
                     busy, done, error, cpu_hold, bus.rx_ready, bus.we);
        end
    endtask

    task automatic test_basic();
        int n0;
        n0 = n_we;
        pulse_start();
        n_cmp++;
        if ({busy, cpu_hold, bus.rx_ready} !== 3'b111) begin
            n_err++;
            $display("FAIL basic_hdr_state: busy%b hold%b rdy%b want 111", busy, cpu_hold, bus.rx_ready);
        end
        send_hdr(16'h0002);
        send_word(5'd0, 32'h0000_0513, 0);
        n_cmp++;
        if (bus.we !== 1'b1) begin
            n_err++;
            $display("FAIL basic_we_latency: we=%b want 1 right after byte 3", bus.we);
        end
        send_word(5'd1, 32'h0010_0593, 0);
        end_load();
        wait_end();
        n_cmp++;
        if ({done, error, cpu_hold, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL basic_status: done%b err%b hold%b busy%b want 1000", done, error, cpu_hold, busy);
        end
        n_cmp++;
        if (n_we - n0 != 2) begin
            n_err++;
            $display("FAIL basic_we_count: got %0d want 2", n_we - n0);
        end
    endtask

    task automatic test_zero();
        int n0;
        n0 = n_we;
        pulse_start();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done_clear: got %b want 0", done);
        end
        send_hdr(16'h0000);
        bus.rx_valid = 1'b0;
        n_cmp++;
        if ({done, busy, cpu_hold, error} !== 4'b1000) begin
            n_err++;
            $display("FAIL zero_status: done%b busy%b hold%b err%b want 1000", done, busy, cpu_hold, error);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_we != n0) begin
            n_err++;
            $display("FAIL zero_we_count: got %0d want 0", n_we - n0);
        end
    endtask

    task automatic test_error();
        int n0;
        n0 = n_we;
        pulse_start();
        send_hdr(16'h0021);
        bus.rx_valid = 1'b0;
        n_cmp++;
        if ({error, cpu_hold, busy, done} !== 4'b1100) begin
            n_err++;
            $display("FAIL err_status: err%b hold%b busy%b done%b want 1100", error, cpu_hold, busy, done);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_we != n0 || error !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: we pulses %0d err%b want 0 and 1", n_we - n0, error);
        end
        pulse_start();
        n_cmp++;
        if (error !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: got %b want 0", error);
        end
        send_hdr(16'h0001);
        send_word(5'd0, 32'hDEAD_BEEF, 0);
        end_load();
        wait_end();
        n_cmp++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            n_err++;
            $display("FAIL err_recover: done%b err%b hold%b want 100", done, error, cpu_hold);
        end
    endtask

    task automatic test_full();
        int n0;
        n0 = n_we;
        pulse_start();
        send_hdr(16'd32);
        for (int i = 0; i < 32; i++) begin
            send_word(5'(i), $urandom, 3);
        end
        end_load();
        wait_end();
        n_cmp++;
        if ({done, error} !== 2'b10) begin
            n_err++;
            $display("FAIL full_status: done%b err%b want 10", done, error);
        end
        n_cmp++;
        if (n_we - n0 != 32 || sb.size() != 0) begin
            n_err++;
            $display("FAIL full_count: writes %0d pending %0d want 32 and 0", n_we - n0, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_hdr(16'h0002);
        send_word(5'd0, 32'h1234_5678, 0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        bus.rx_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, error, cpu_hold, bus.rx_ready, bus.we, bus.waddr, bus.wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: busy%b done%b err%b hold%b rdy%b we%b waddr%0d wdata%h, want all 0",
                     busy, done, error, cpu_hold, bus.rx_ready, bus.we, bus.waddr, bus.wdata);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        pulse_start();
        send_hdr(16'h0001);
        send_word(5'd0, 32'hCAFE_F00D, 0);
        end_load();
        wait_end();
        n_cmp++;
        if (done !== 1'b1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL reset_reload: done%b pending %0d want 1 and 0", done, sb.size());
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        pulse_start();
        send_hdr(16'h0001);
        send_word(5'd0, 32'hF00F_55AA, 0);
        send_byte(8'h00);
        bus.rx_valid = 1'b0;
        wait_end();
        n_cmp++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            n_err++;
            $display("FAIL csum_good: done%b err%b hold%b want 100", done, error, cpu_hold);
        end
        pulse_start();
        send_hdr(16'h0001);
        send_word(5'd0, 32'hF00F_55AA, 0);
        send_byte(8'h01);
        bus.rx_valid = 1'b0;
        wait_end();
        n_cmp++;
        if ({done, error, cpu_hold} !== 3'b011 || sb.size() != 0) begin
            n_err++;
            $display("FAIL csum_bad: done%b err%b hold%b pending %0d want 011 and 0",
                     done, error, cpu_hold, sb.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_error();
        test_full();
        test_reset_mid();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d writes still expected, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
